llc_seq_ctrl: RTL and testbench



---
 rtl/llc_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_llc_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/llc_seq_ctrl.sv
// llc_seq_ctrl: LLC pipeline sequencer. Arbitrates NUM_IN request channels
// (fixed or round-robin), then steps READ_SET / READ_MEM (RD_LAT cycles) /
// LOOKUP / PROCESS / UPDATE / optional RESUME, emitting datapath enables.
// Ports: clk, rst (async active-low); in_valid/in_set/stall_mask -> in_ready
// (one-hot grant in DECODE); rd_en/rd_set/cur_ch; lookup_en; process_en with
// process_done; update_en; resume_req -> resume_valid/resume_ready; idle;
// proc_timeout (sticky watchdog); txn_count (wrapping completed count).
module llc_seq_ctrl #(
    parameter int NUM_IN   = 4,
    parameter int SET_BITS = 9,
    parameter int RD_LAT   = 1,
    parameter int ARB_RR   = 0,
    parameter int MAX_PROC = 255,
    localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_IN-1:0]          in_valid,
    input  logic [NUM_IN*SET_BITS-1:0] in_set,
    input  logic [NUM_IN-1:0]          stall_mask,
    output logic [NUM_IN-1:0]          in_ready,
    output logic                       rd_en,
    output logic [SET_BITS-1:0]        rd_set,
    output logic [CW-1:0]              cur_ch,
    output logic                       lookup_en,
    output logic                       process_en,
    input  logic                       process_done,
    output logic                       update_en,
    input  logic                       resume_req,
    output logic                       resume_valid,
    input  logic                       resume_ready,
    output logic                       idle,
    output logic                       proc_timeout,
    output logic [15:0]                txn_count
);

    typedef enum logic [2:0] {
        DECODE, READ_SET, READ_MEM, LOOKUP, PROCESS, UPDATE, RESUME
    } state_t;

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] rd_set_q, rd_set_d;
    logic [CW-1:0]       cur_ch_q, cur_ch_d;
    logic [CW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]          lat_cnt_q, lat_cnt_d;
    logic [15:0]         proc_cnt_q, proc_cnt_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         txn_q, txn_d;

    logic [NUM_IN-1:0]   elig;
    logic [NUM_IN-1:0]   gnt;
    logic                found;
    logic [CW-1:0]       win;
    int                  idx;

    // Scan starts at rr_ptr in round-robin mode, at 0 in fixed mode.
    always_comb begin
        elig  = in_valid & ~stall_mask;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ARB_RR != 0) idx = (int'(rr_ptr_q) + k) % NUM_IN;
            else             idx = k;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = CW'(idx);
            end
        end
        gnt = found ? (NUM_IN'(1) << win) : '0;
    end

    always_comb begin
        state_d    = state_q;
        rd_set_d   = rd_set_q;
        cur_ch_d   = cur_ch_q;
        rr_ptr_d   = rr_ptr_q;
        lat_cnt_d  = lat_cnt_q;
        proc_cnt_d = proc_cnt_q;
        tmo_d      = tmo_q;
        txn_d      = txn_q;
        unique case (state_q)
            DECODE: begin
                if (found) begin
                    cur_ch_d = win;
                    rd_set_d = in_set[int'(win)*SET_BITS +: SET_BITS];
                    if (ARB_RR != 0)
                        rr_ptr_d = (win == CW'(NUM_IN-1)) ? '0 : win + 1'b1;
                    state_d = READ_SET;
                end
            end
            READ_SET: begin
                lat_cnt_d = 3'(RD_LAT-1);
                state_d   = READ_MEM;
            end
            READ_MEM: begin
                if (lat_cnt_q == '0) state_d = LOOKUP;
                else lat_cnt_d = lat_cnt_q - 1'b1;
            end
            LOOKUP: begin
                proc_cnt_d = '0;
                state_d    = PROCESS;
            end
            PROCESS: begin
                proc_cnt_d = proc_cnt_q + 1'b1;
                if (process_done) begin
                    state_d = UPDATE;
                end else if (proc_cnt_q == 16'(MAX_PROC-1)) begin
                    tmo_d   = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                txn_d   = txn_q + 1'b1;
                state_d = resume_req ? RESUME : DECODE;
            end
            RESUME: begin
                if (resume_ready) state_d = DECODE;
            end
            default: state_d = DECODE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DECODE;
            rd_set_q   <= '0;
            cur_ch_q   <= '0;
            rr_ptr_q   <= '0;
            lat_cnt_q  <= '0;
            proc_cnt_q <= '0;
            tmo_q      <= 1'b0;
            txn_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_set_q   <= rd_set_d;
            cur_ch_q   <= cur_ch_d;
            rr_ptr_q   <= rr_ptr_d;
            lat_cnt_q  <= lat_cnt_d;
            proc_cnt_q <= proc_cnt_d;
            tmo_q      <= tmo_d;
            txn_q      <= txn_d;
        end
    end

    // Grant is gated by rst so nothing is offered while held in reset.
    assign in_ready     = (state_q == DECODE && rst) ? gnt : '0;
    assign rd_en        = (state_q == READ_SET) || (state_q == READ_MEM);
    assign lookup_en    = (state_q == LOOKUP);
    assign process_en   = (state_q == LOOKUP) || (state_q == PROCESS);
    assign update_en    = (state_q == UPDATE);
    assign resume_valid = (state_q == RESUME);
    assign idle         = (state_q == DECODE);
    assign rd_set       = rd_set_q;
    assign cur_ch       = cur_ch_q;
    assign proc_timeout = tmo_q;
    assign txn_count    = txn_q;

endmodule

// File: tb/tb_llc_seq_ctrl.sv
// tb_llc_seq_ctrl: directed bench for llc_seq_ctrl.
// Instance a: fixed priority, RD_LAT=1, MAX_PROC=8. Instance b: RR, RD_LAT=3.
module tb_llc_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance a ----------------
    logic        a_rst = 1'b1;
    logic [3:0]  a_valid = '0, a_stall = '0, a_ready;
    logic [35:0] a_set = '0;
    logic        a_rd_en, a_lookup_en, a_process_en, a_update_en;
    logic [8:0]  a_rd_set;
    logic [1:0]  a_cur_ch;
    logic        a_done = 1'b0, a_rreq = 1'b0, a_rrdy = 1'b0;
    logic        a_rvalid, a_idle, a_tmo;
    logic [15:0] a_txn;

    llc_seq_ctrl #(.NUM_IN(4), .SET_BITS(9), .RD_LAT(1), .ARB_RR(0),
                   .MAX_PROC(8)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_valid), .in_set(a_set),
        .stall_mask(a_stall), .in_ready(a_ready), .rd_en(a_rd_en),
        .rd_set(a_rd_set), .cur_ch(a_cur_ch), .lookup_en(a_lookup_en),
        .process_en(a_process_en), .process_done(a_done),
        .update_en(a_update_en), .resume_req(a_rreq),
        .resume_valid(a_rvalid), .resume_ready(a_rrdy), .idle(a_idle),
        .proc_timeout(a_tmo), .txn_count(a_txn)
    );

    // ---------------- instance b ----------------
    logic        b_rst = 1'b1;
    logic [3:0]  b_valid = '0, b_stall = '0, b_ready;
    logic [35:0] b_set = '0;
    logic        b_rd_en, b_lookup_en, b_process_en, b_update_en;
    logic [8:0]  b_rd_set;
    logic [1:0]  b_cur_ch;
    logic        b_done = 1'b0, b_rreq = 1'b0, b_rrdy = 1'b0;
    logic        b_rvalid, b_idle, b_tmo;
    logic [15:0] b_txn;

    llc_seq_ctrl #(.NUM_IN(4), .SET_BITS(9), .RD_LAT(3), .ARB_RR(1),
                   .MAX_PROC(255)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .in_set(b_set),
        .stall_mask(b_stall), .in_ready(b_ready), .rd_en(b_rd_en),
        .rd_set(b_rd_set), .cur_ch(b_cur_ch), .lookup_en(b_lookup_en),
        .process_en(b_process_en), .process_done(b_done),
        .update_en(b_update_en), .resume_req(b_rreq),
        .resume_valid(b_rvalid), .resume_ready(b_rrdy), .idle(b_idle),
        .proc_timeout(b_tmo), .txn_count(b_txn)
    );

    // {in_ready[3:0], rd_en, lookup_en, process_en, update_en, idle}
    logic [8:0] a_exp [7];
    logic [8:0] b_exp [9];
    logic [8:0] ex;
    logic [3:0] rr_exp [3];
    int nv, ng;

    initial begin
        a_exp[0] = 9'b0010_0000_1;
        a_exp[1] = 9'b0000_1000_0;
        a_exp[2] = 9'b0000_1000_0;
        a_exp[3] = 9'b0000_0110_0;
        a_exp[4] = 9'b0000_0010_0;
        a_exp[5] = 9'b0000_0001_0;
        a_exp[6] = 9'b0010_0000_1;
        b_exp[0] = 9'b0001_0000_1;
        b_exp[1] = 9'b0000_1000_0;
        b_exp[2] = 9'b0000_1000_0;
        b_exp[3] = 9'b0000_1000_0;
        b_exp[4] = 9'b0000_1000_0;
        b_exp[5] = 9'b0000_0110_0;
        b_exp[6] = 9'b0000_0010_0;
        b_exp[7] = 9'b0000_0001_0;
        b_exp[8] = 9'b0010_0000_1;
        rr_exp[0] = 4'b0100;
        rr_exp[1] = 4'b1000;
        rr_exp[2] = 4'b0001;

        a_set = {9'h1FF, 9'h033, 9'h122, 9'h011};
        b_set = {9'h0C3, 9'h0B2, 9'h0A1, 9'h090};
        a_valid = 4'b1111;
        a_stall = 4'b0001;
        a_done  = 1'b1;
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        chk("rst_idle", a_idle, 1);
        chk("rst_ready", a_ready, 0);
        chk("rst_rd_en", a_rd_en, 0);
        chk("rst_txn", a_txn, 0);
        chk("rst_cur_ch", a_cur_ch, 0);
        chk("rst_rd_set", a_rd_set, 0);
        chk("rst_tmo", a_tmo, 0);
        chk("rst_rvalid", a_rvalid, 0);
        tick();
        tick();
        chk("rst_held_ready", a_ready, 0);
        a_rst = 1'b1;
        #1;

        // Fixed priority, ch0 stalled: ch1 wins, 6-cycle grant spacing.
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            ex = {a_ready, a_rd_en, a_lookup_en, a_process_en,
                  a_update_en, a_idle};
            chk($sformatf("fix_cyc%0d", i), ex, a_exp[i]);
            if (i == 1) begin
                chk("fix_cur_ch", a_cur_ch, 1);
                chk("fix_rd_set", a_rd_set, 9'h122);
            end
        end
        chk("fix_txn1", a_txn, 1);
        chk("fix_hold_set", a_rd_set, 9'h122);

        // Watchdog: done low; done pulse in LOOKUP must be ignored.
        a_done = 1'b0;
        repeat (3) tick();
        chk("wd_lookup", a_lookup_en, 1);
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
        chk("wd_lk_done_ign", {a_process_en, a_update_en}, 2'b10);
        repeat (7) tick();
        chk("wd_last_proc", {a_process_en, a_tmo}, 2'b10);
        tick();
        chk("wd_update", {a_update_en, a_tmo}, 2'b11);
        tick();
        chk("wd_decode", {a_idle, a_ready}, 5'b1_0010);
        chk("wd_txn", a_txn, 2);

        // Resume with ready held low: valid 5 cycles, no grants.
        a_done = 1'b1;
        a_rreq = 1'b1;
        a_rrdy = 1'b0;
        repeat (5) tick();
        chk("rs_update", a_update_en, 1);
        nv = 0;
        ng = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (a_rvalid) nv++;
            if (a_ready != 0) ng++;
            if (k == 4) a_rrdy = 1'b1;
        end
        chk("rs_valid_cycles", nv, 5);
        chk("rs_no_grant", ng, 0);
        tick();
        chk("rs_drop", a_rvalid, 0);
        chk("rs_grant_next", a_ready, 4'b0010);
        chk("rs_txn", a_txn, 3);
        chk("rs_tmo_sticky", a_tmo, 1);
        a_rreq = 1'b0;
        a_rrdy = 1'b0;

        // Reset in READ_MEM aborts the transaction.
        repeat (2) tick();
        chk("mr_in_rdmem", {a_rd_en, a_idle}, 2'b10);
        a_rst = 1'b0;
        #1;
        ex = {a_ready, a_rd_en, a_lookup_en, a_process_en,
              a_update_en, a_idle};
        chk("mr_outputs", ex, 9'b0000_0000_1);
        chk("mr_txn", a_txn, 0);
        chk("mr_tmo", a_tmo, 0);
        chk("mr_state", {a_cur_ch, a_rd_set, a_rvalid}, 0);

        // Round-robin, RD_LAT=3.
        b_valid = 4'b1111;
        b_stall = 4'b0000;
        b_done  = 1'b1;
        tick();
        b_rst = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            ex = {b_ready, b_rd_en, b_lookup_en, b_process_en,
                  b_update_en, b_idle};
            chk($sformatf("rr_cyc%0d", i), ex, b_exp[i]);
        end
        for (int g = 0; g < 3; g++) begin
            repeat (8) tick();
            chk($sformatf("rr_grant%0d", g + 2), b_ready, rr_exp[g]);
        end
        chk("rr_txn", b_txn, 4);
        repeat (8) tick();
        b_valid = 4'b1000;
        #1;
        chk("rr_only3", {b_idle, b_ready}, 5'b1_1000);
        tick();
        chk("rr_cur_ch3", b_cur_ch, 3);
        chk("rr_rd_set3", b_rd_set, 9'h0C3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
